// File: rtl/dct_8_muladd_pkg.sv
// Shared widths and signed types for the 8-lane DCT multiply-accumulate.
// Build option DCT_MULADD_SATURATE_EN (used by the top) clamps instead of wrapping.
package dct_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned DATA_DEPTH = 8;
  localparam int unsigned FRAC_BITS  = 16;
  localparam int unsigned ACC_WIDTH  = 2 * DATA_WIDTH + $clog2(DATA_DEPTH);

  typedef logic signed [DATA_WIDTH-1:0]   lane_t;
  typedef logic signed [2*DATA_WIDTH-1:0] prod_t;
  typedef logic signed [ACC_WIDTH-1:0]    acc_t;

endpackage

// File: rtl/dct_8_muladd_if.sv
// Sample/coefficient vector bus and result for the DCT multiply-accumulate.
interface dct_8_muladd_if import dct_pkg::*; ();

  logic [DATA_WIDTH*DATA_DEPTH-1:0] data_in;
  logic [DATA_WIDTH*DATA_DEPTH-1:0] coeff;
  lane_t                            data_out;

  modport master (output data_in, output coeff, input data_out);
  modport slave  (input data_in, input coeff, output data_out);

endinterface

// File: rtl/dct_8_muladd_lane_mul.sv
// Registered signed lane multiplier producing the full-width product.
module dct_lane_mul
  import dct_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  lane_t i_data,
  input  lane_t i_coeff,
  output prod_t o_prod
);

  prod_t r_prod;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prod <= '0;
    end else begin
      r_prod <= prod_t'(i_data) * prod_t'(i_coeff);
    end
  end

  assign o_prod = r_prod;

endmodule

// File: rtl/dct_8_muladd.sv
// Two-stage 8-lane signed dot product, rescaled by FRAC_BITS to DATA_WIDTH.
// DCT_MULADD_SATURATE_EN: clamp the rescaled sum instead of wrapping.
module dct_8_muladd
  import dct_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  dct_8_muladd_if.slave bus
);

  prod_t w_prod [DATA_DEPTH];
  acc_t  w_sum;
  lane_t w_res;
  lane_t r_out;

  for (genvar g = 0; g < DATA_DEPTH; g++) begin : g_lane
    dct_lane_mul u_mul (
      .clk     (clk),
      .reset   (reset),
      .i_data  (lane_t'(bus.data_in[g*DATA_WIDTH +: DATA_WIDTH])),
      .i_coeff (lane_t'(bus.coeff[g*DATA_WIDTH +: DATA_WIDTH])),
      .o_prod  (w_prod[g])
    );
  end

  // Accumulator is wide enough that the sum of all products never overflows.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < DATA_DEPTH; i++) begin
      w_sum = w_sum + acc_t'(w_prod[i]);
    end
  end

`ifdef DCT_MULADD_SATURATE_EN
  localparam acc_t SatMax = {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam acc_t SatMin = {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  acc_t w_shift;

  always_comb begin
    w_shift = w_sum >>> FRAC_BITS;
    if (w_shift > SatMax) begin
      w_res = lane_t'(SatMax);
    end else if (w_shift < SatMin) begin
      w_res = lane_t'(SatMin);
    end else begin
      w_res = lane_t'(w_shift);
    end
  end
`else
  // Floor shift then two's-complement wrap into the lane width.
  always_comb begin
    w_res = lane_t'(w_sum >>> FRAC_BITS);
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out <= '0;
    end else begin
      r_out <= w_res;
    end
  end

  assign bus.data_out = r_out;

endmodule

// File: tb/tb_dct_8_muladd.sv
// Randomized and directed bench for dct_8_muladd against a wide-integer dot-product model.
module tb_dct_8_muladd;
  import dct_pkg::*;

  logic clk;
  logic reset;
  logic [DATA_WIDTH*DATA_DEPTH-1:0] din;
  logic [DATA_WIDTH*DATA_DEPTH-1:0] cf;
  logic [31:0] exp_mid;
  logic [31:0] exp_out;
  int n_total;
  int n_bad;

  dct_8_muladd_if bus ();

  dct_8_muladd dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, want);
    end
  endtask

  // Exact dot product in 128-bit integers, floor-scaled, then wrapped or clamped.
  function automatic logic [31:0] ref_dot(input logic [255:0] d, input logic [255:0] c);
    logic signed [127:0] acc;
    logic signed [127:0] a;
    logic signed [127:0] b;
    acc = '0;
    for (int i = 0; i < 8; i++) begin
      a = signed'(d[i*32 +: 32]);
      b = signed'(c[i*32 +: 32]);
      acc = acc + a * b;
    end
    acc = acc >>> 16;
`ifdef DCT_MULADD_SATURATE_EN
    if (acc > 128'sh7FFF_FFFF) return 32'h7FFF_FFFF;
    if (acc < -128'sh8000_0000) return 32'h8000_0000;
`endif
    return acc[31:0];
  endfunction

  // One clock: the model is a two-deep delay line of ideal results, cleared by reset.
  task automatic tick();
    logic [31:0] nxt;
    bus.data_in = din;
    bus.coeff   = cf;
    nxt = ref_dot(din, cf);
    @(posedge clk);
    #1;
    if (reset) begin
      exp_mid = '0;
      exp_out = '0;
    end else begin
      exp_out = exp_mid;
      exp_mid = nxt;
    end
  endtask

  task automatic fill(input logic [31:0] dv, input logic [31:0] cv);
    for (int i = 0; i < 8; i++) begin
      din[i*32 +: 32] = dv;
      cf[i*32 +: 32]  = cv;
    end
  endtask

  task automatic randomize_vec();
    for (int i = 0; i < 8; i++) begin
      din[i*32 +: 32] = $urandom;
      cf[i*32 +: 32]  = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 32'h0002_0000);
    end
  endtask

  task automatic run_directed(input string tag, input logic [31:0] want);
    tick();
    tick();
    check_val(tag, bus.data_out, want);
    check_val({tag, "_model"}, bus.data_out, exp_out);
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    exp_mid = '0;
    exp_out = '0;
    reset   = 1'b1;
    randomize_vec();
    tick();
    check_val("reset_edge1", bus.data_out, 32'h0);
    randomize_vec();
    tick();
    check_val("reset_edge2", bus.data_out, 32'h0);

    // Integer samples times unity, held across reset release.
    for (int i = 0; i < 8; i++) begin
      din[i*32 +: 32] = 32'(i + 1);
      cf[i*32 +: 32]  = 32'h0001_0000;
    end
    reset = 1'b0;
    tick();
    check_val("release_edge1", bus.data_out, 32'h0);
    tick();
    check_val("release_edge2", bus.data_out, 32'h0000_0024);

    fill(32'h0001_0000, 32'h0000_8000);
    run_directed("fractional", 32'h0004_0000);

    fill(32'hFFFF_FFFF, 32'h0000_8000);
    run_directed("neg_all", 32'hFFFF_FFFC);

    fill(32'h0, 32'h0000_8000);
    din[31:0] = 32'hFFFF_FFFF;
    run_directed("floor_neg_half", 32'hFFFF_FFFF);

    din[31:0] = 32'h0000_0001;
    run_directed("floor_pos_half", 32'h0);

    fill(32'h7FFF_FFFF, 32'h0001_0000);
`ifdef DCT_MULADD_SATURATE_EN
    run_directed("overflow_sat", 32'h7FFF_FFFF);
`else
    run_directed("overflow_wrap", 32'hFFFF_FFF8);
`endif

    // Streaming with a new vector every cycle and a single-cycle reset in the middle.
    for (int n = 0; n < 200; n++) begin
      randomize_vec();
      reset = (n == 100);
      tick();
      check_val("stream", bus.data_out, exp_out);
      if (n == 100) check_val("stream_reset_zero", bus.data_out, 32'h0);
    end
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
